// File: rtl/fwd_scoreboard.sv
// In-flight destination tracker: shifts one write tag per issued instruction through
// NSTAGE post-issue slots and resolves decode operands to forward data or a stall.
module fwd_scoreboard #(
    parameter int NSTAGE     = 3,
    parameter int WORD_W     = 32,
    parameter int RSEL_W     = 5,
    parameter int ALU_READY  = 0,
    parameter int LOAD_READY = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     advance,
    input  logic [NSTAGE-1:0]        flush,
    input  logic                     issue_valid,
    input  logic                     issue_regwr,
    input  logic                     issue_load,
    input  logic [RSEL_W-1:0]        issue_wsel,
    input  logic [RSEL_W-1:0]        rs,
    input  logic [RSEL_W-1:0]        rt,
    input  logic [NSTAGE*WORD_W-1:0] stage_wdat,
    output logic                     fwd_a_hit,
    output logic [WORD_W-1:0]        fwd_a_data,
    output logic                     fwd_b_hit,
    output logic [WORD_W-1:0]        fwd_b_data,
    output logic                     stall_req,
    output logic                     busy
);

    logic [NSTAGE-1:0] vld_p;
    logic [NSTAGE-1:0] load_p;
    logic [RSEL_W-1:0] wsel_p [NSTAGE];
    logic [NSTAGE-1:0] vld_shift;
    logic [NSTAGE-1:0] vld_next;
    logic              pend_a;
    logic              pend_b;

    function automatic logic slot_ready(input int k, input logic ld);
        return ld ? (k >= LOAD_READY) : (k >= ALU_READY);
    endfunction

    // Scan oldest to youngest so the youngest matching producer overrides the rest.
    function automatic logic [WORD_W+1:0] resolve(input logic [RSEL_W-1:0] src);
        logic              hit;
        logic              pend;
        logic [WORD_W-1:0] data;
        hit  = 1'b0;
        pend = 1'b0;
        data = '0;
        for (int k = NSTAGE-1; k >= 0; k--) begin
            if (vld_p[k] && (wsel_p[k] == src) && (src != '0)) begin
                if (slot_ready(k, load_p[k])) begin
                    hit  = 1'b1;
                    pend = 1'b0;
                    data = stage_wdat[k*WORD_W +: WORD_W];
                end else begin
                    hit  = 1'b0;
                    pend = 1'b1;
                    data = '0;
                end
            end
        end
        return {pend, hit, data};
    endfunction

    always_comb begin
        {pend_a, fwd_a_hit, fwd_a_data} = resolve(rs);
        {pend_b, fwd_b_hit, fwd_b_data} = resolve(rt);
        stall_req = pend_a | pend_b;
        busy      = |vld_p;
    end

    // Stalled issues enter slot 0 as bubbles; flush is applied to final slot positions.
    always_comb begin
        vld_shift = vld_p;
        if (advance) begin
            vld_shift = {vld_p[NSTAGE-2:0], issue_valid & issue_regwr & ~stall_req};
        end
        vld_next = vld_shift & ~flush;
    end

    // Slot shift boundary: control
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_p <= '0;
        end else begin
            vld_p <= vld_next;
        end
    end

    // Slot shift boundary: tag payload
    always_ff @(posedge CLK) begin
        if (advance) begin
            load_p[0] <= issue_load;
            wsel_p[0] <= issue_wsel;
            for (int k = 1; k < NSTAGE; k++) begin
                load_p[k] <= load_p[k-1];
                wsel_p[k] <= wsel_p[k-1];
            end
        end
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised in-flight write tracker for the pipelined core.
- Generalises fixed two-stage EX forwarding and single load-use hazard detection to an arbitrary number of post-issue stages, with configurable result-ready points for ALU results and loads.
- Shifts a destination tag per issued instruction through NSTAGE slots. Resolves decode-stage source operands to the youngest pending producer: forward its data, or request a stall if that data is not yet produced.
- Sits between decode/issue and the execute stage; replaces ad-hoc forward and load-use logic in the datapath.

Parameters:
- NSTAGE, 3, number of tracked post-issue slots (slot 0 = EX, slot NSTAGE-1 = WB); legal range 2..8.
- WORD_W, 32, forwarded data width.
- RSEL_W, 5, register select width.
- ALU_READY, 0, lowest slot index whose stage_wdat holds a valid non-load result.
- LOAD_READY, 2, lowest slot index whose stage_wdat holds valid load data; must satisfy ALU_READY <= LOAD_READY <= NSTAGE-1.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- advance  in  1  pipeline moves this cycle (0 = global stall, e.g. cache miss).
- flush  in  NSTAGE  per-slot clear; bit k kills slot k at this edge.
- issue_valid  in  1  decode holds a real instruction.
- issue_regwr  in  1  instruction writes a register.
- issue_load  in  1  instruction is a memory load.
- issue_wsel  in  RSEL_W  destination register.
- rs  in  RSEL_W  decode source A.
- rt  in  RSEL_W  decode source B.
- stage_wdat  in  NSTAGE*WORD_W  slot k result at bits [k*WORD_W +: WORD_W].
- fwd_a_hit  out  1  source A has a pending producer whose data is ready.
- fwd_a_data  out  WORD_W  forwarded value for A (0 when no hit).
- fwd_b_hit  out  1  same, for B.
- fwd_b_data  out  WORD_W  same, for B.
- stall_req  out  1  decode must hold; a bubble is inserted.
- busy  out  1  any slot valid.

Behaviour:
- State per slot k: v[k], load[k], wsel[k]. Only entries with issue_regwr=1 become valid; non-writing instructions enter as v=0.
- Reset (async, RST=1): all v=0. Outputs then: hits 0, data 0, stall_req 0, busy 0. Reset mid-stall discards all tags immediately.
- Match for source s in slot k: v[k] & (wsel[k]==s) & (s!=0). Register 0 never matches.
- Youngest (lowest k) match is authoritative. Older matches are ignored even if ready.
- Ready(k) = load[k] ? (k>=LOAD_READY) : (k>=ALU_READY).
- Youngest match ready: hit=1, data = stage_wdat slot k.
- Youngest match not ready: hit=0, data=0, contributes to stall_req.
- stall_req = (A not-ready match) | (B not-ready match). Purely combinational; no extra latency.
- On edge with advance=1:
  - slot k+1 <= slot k for k=0..NSTAGE-2.
  - Slot NSTAGE-1 retires (dropped).
  - Slot 0 <= {issue_valid & issue_regwr & ~stall_req, issue_load, issue_wsel}. A stalled issue becomes a bubble.
- On edge with advance=0: all slots hold.
- flush applies after shift/hold at the same edge: any slot whose final position k has flush[k]=1 gets v=0. Flush wins over a simultaneous issue into slot 0.
- The WB slot is forwardable; the register file is not assumed to be write-through.
- busy = OR of v[].

Test Plan:
- Reset, then issue add to r8 (regwr=1, load=0), advance=1. Next cycle rs=8, stage_wdat slot0=0x0000_1234 -> fwd_a_hit=1, fwd_a_data=0x0000_1234, stall_req=0.
- Issue lw to r9, advance each cycle; query rt=9:
  - cycles 1-2 -> stall_req=1, fwd_b_hit=0;
  - cycle 3 (slot 2) -> fwd_b_hit=1, data=slot2 value;
  - a bubble fills slot 0 during each stall.
- r5 written by slot 2 (value 0xAAAA) and slot 0 (value 0x5555); rs=5 -> fwd_a_data=0x5555. If the slot 0 writer is a load -> stall_req=1 with no fallback to 0xAAAA.
- rs=0 with slot 0 writing r0 -> fwd_a_hit=0, stall_req=0.
- advance=0 for 4 cycles with a load in slot 1 -> tags frozen, stall_req stays 1. flush=3'b011 at that edge -> slots 0-1 cleared, stall_req=0.
- Assert RST mid-sequence with 3 valid slots -> busy=0 and all hits 0 immediately, before the next clock edge.
